// File: rtl/spi_tx_sequencer.sv
`default_nettype none
// ============================================================================
// spi_tx_sequencer : byte FIFO that launches one SPI-master transfer per byte
// Rev 1.0 - initial release
// ============================================================================
module spi_tx_sequencer #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 255,
   parameter int AW      = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    i_tx_data,
   input  logic          i_tx_valid,
   output logic          o_tx_ready,
   output logic [AW:0]   o_level,
   output logic [7:0]    o_rx_data,
   output logic          o_rx_valid,
   output logic [7:0]    o_m_data_in,
   output logic          o_m_en,
   input  logic          i_m_busy,
   input  logic [7:0]    i_m_data_out,
   output logic          o_err_timeout,
   input  logic          i_clr_err
);

   localparam int            TW         = 16;
   localparam logic [AW:0]   c_full     = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2
   } state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_count;
   logic [1:0]    r_sync;
   state_t        r_state;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_din;
   logic          r_en;
   logic [7:0]    r_rxd;
   logic          r_rxv;
   logic          r_err;

   logic          w_push;
   logic          w_pop;
   logic          w_busy_s;
   state_t        w_state_nx;
   logic [TW-1:0] w_tmo_nx;
   logic [7:0]    w_din_nx;
   logic          w_en_nx;
   logic [7:0]    w_rxd_nx;
   logic          w_rxv_nx;
   logic          w_err_set;

   assign o_tx_ready    = (r_count != c_full);
   assign w_push        = i_tx_valid && o_tx_ready;
   assign w_busy_s      = r_sync[1];
   assign o_level       = r_count;
   assign o_rx_data     = r_rxd;
   assign o_rx_valid    = r_rxv;
   assign o_m_data_in   = r_din;
   assign o_m_en        = r_en;
   assign o_err_timeout = r_err;

   // Storage is not reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr] <= i_tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // m_busy comes from the sck domain; only the second flop is ever used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], i_m_busy};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tmo   <= '0;
         r_din   <= 8'h00;
         r_en    <= 1'b0;
         r_rxd   <= 8'h00;
         r_rxv   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_tmo   <= w_tmo_nx;
         r_din   <= w_din_nx;
         r_en    <= w_en_nx;
         r_rxd   <= w_rxd_nx;
         r_rxv   <= w_rxv_nx;
         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (i_clr_err) begin
            r_err <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_tmo_nx   = r_tmo;
      w_din_nx   = r_din;
      w_en_nx    = r_en;
      w_rxd_nx   = r_rxd;
      w_rxv_nx   = 1'b0;
      w_err_set  = 1'b0;
      w_pop      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_en_nx = 1'b0;
            if (r_count != '0) begin
               w_pop      = 1'b1;
               w_din_nx   = r_mem[r_rd];
               w_en_nx    = 1'b1;
               w_tmo_nx   = '0;
               w_state_nx = S_REQ;
            end
         end
         S_REQ: begin
            w_tmo_nx = r_tmo + 1'b1;
            // A busy flag still high from before counts as the acknowledge.
            if (w_busy_s) begin
               w_en_nx    = 1'b0;
               w_state_nx = S_XFER;
            end else if (r_tmo == c_tmo_last) begin
               w_en_nx    = 1'b0;
               w_err_set  = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         S_XFER: begin
            w_en_nx = 1'b0;
            if (!w_busy_s) begin
               w_rxd_nx   = i_m_data_out;
               w_rxv_nx   = 1'b1;
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            w_en_nx    = 1'b0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
